// File: rtl/button_bank.sv
// Multi-channel push-button front end: synchroniser, debouncer,
// edge pulses and long-press / auto-repeat detection per channel.
module button_bank #(
  parameter int N               = 5,
  parameter int DEBOUNCE_CYCLES = 2000,
  parameter int HOLD_CYCLES     = 50000000,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_CYCLES   = 10000000
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] bt,
  output logic [N-1:0] level,
  output logic [N-1:0] press,
  output logic [N-1:0] release_pulse,
  output logic [N-1:0] long_press,
  output logic [N-1:0] repeat_pulse,
  output logic         any_press
);

  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HW = $clog2(HOLD_CYCLES + 1);
  localparam int RW = $clog2(REPEAT_CYCLES + 1);

  localparam logic [DW-1:0] D_LAST = DW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] H_LAST = HW'(HOLD_CYCLES - 1);
  localparam logic [RW-1:0] R_LAST = RW'(REPEAT_CYCLES - 1);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    HOLDING = 2'd1,
    LONG    = 2'd2
  } hold_e;

  logic [N-1:0] sync1_q;
  logic [N-1:0] sync2_q;

  logic [N-1:0] level_q, level_d;
  logic [N-1:0] press_q, press_d;
  logic [N-1:0] release_q, release_d;
  logic [N-1:0] long_q, long_d;
  logic [N-1:0] repeat_q, repeat_d;
  logic         any_q, any_d;

  logic [DW-1:0] dcnt_q [N];
  logic [DW-1:0] dcnt_d [N];
  logic [HW-1:0] hcnt_q [N];
  logic [HW-1:0] hcnt_d [N];
  logic [RW-1:0] rcnt_q [N];
  logic [RW-1:0] rcnt_d [N];
  hold_e         state_q [N];
  hold_e         state_d [N];

  // Accept a new level only after it has been seen for DEBOUNCE_CYCLES in a row
  always_comb begin
    level_d = level_q;
    for (int i = 0; i < N; i++) begin
      dcnt_d[i] = '0;
      if (sync2_q[i] != level_q[i]) begin
        if (dcnt_q[i] == D_LAST) begin
          level_d[i] = sync2_q[i];
        end else begin
          dcnt_d[i] = dcnt_q[i] + 1'b1;
        end
      end
    end
    press_d   = level_d & ~level_q;
    release_d = ~level_d & level_q;
    any_d     = |press_d;
  end

  // Hold tracking; a release always wins and silences long/repeat
  always_comb begin
    long_d   = '0;
    repeat_d = '0;
    for (int i = 0; i < N; i++) begin
      state_d[i] = state_q[i];
      hcnt_d[i]  = hcnt_q[i];
      rcnt_d[i]  = rcnt_q[i];
      if (release_d[i]) begin
        state_d[i] = IDLE;
        hcnt_d[i]  = '0;
        rcnt_d[i]  = '0;
      end else if (press_d[i]) begin
        state_d[i] = HOLDING;
        hcnt_d[i]  = '0;
        rcnt_d[i]  = '0;
      end else begin
        unique case (state_q[i])
          IDLE: begin
            hcnt_d[i] = '0;
            rcnt_d[i] = '0;
          end
          HOLDING: begin
            if (hcnt_q[i] == H_LAST) begin
              long_d[i]  = 1'b1;
              state_d[i] = LONG;
              rcnt_d[i]  = '0;
            end else begin
              hcnt_d[i] = hcnt_q[i] + 1'b1;
            end
          end
          LONG: begin
            if (REPEAT_EN != 0) begin
              if (rcnt_q[i] == R_LAST) begin
                repeat_d[i] = 1'b1;
                rcnt_d[i]   = '0;
              end else begin
                rcnt_d[i] = rcnt_q[i] + 1'b1;
              end
            end else begin
              rcnt_d[i] = '0;
            end
          end
          default: begin
            state_d[i] = IDLE;
            hcnt_d[i]  = '0;
            rcnt_d[i]  = '0;
          end
        endcase
      end
    end
  end

  // Synchroniser, debounce and hold state with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1_q   <= '0;
      sync2_q   <= '0;
      level_q   <= '0;
      press_q   <= '0;
      release_q <= '0;
      long_q    <= '0;
      repeat_q  <= '0;
      any_q     <= 1'b0;
      for (int i = 0; i < N; i++) begin
        dcnt_q[i]  <= '0;
        hcnt_q[i]  <= '0;
        rcnt_q[i]  <= '0;
        state_q[i] <= IDLE;
      end
    end else begin
      sync1_q   <= bt;
      sync2_q   <= sync1_q;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
      repeat_q  <= repeat_d;
      any_q     <= any_d;
      for (int i = 0; i < N; i++) begin
        dcnt_q[i]  <= dcnt_d[i];
        hcnt_q[i]  <= hcnt_d[i];
        rcnt_q[i]  <= rcnt_d[i];
        state_q[i] <= state_d[i];
      end
    end
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = release_q;
  assign long_press    = long_q;
  assign repeat_pulse  = repeat_q;
  assign any_press     = any_q;

endmodule

// File: doc/button_bank.md
Name: button_bank

Overview:
- Parametrised multi-channel push-button front end that replaces the single-channel rising-edge/lockout block.
- Per channel:
  - 2-FF synchroniser
  - stable-time debouncer
  - registered debounced level
  - one-cycle press and release pulses
  - long-press detection, with optional auto-repeat
- Sits between board buttons and the CPU I/O / control logic; all outputs are synchronous to clk and safe to use directly in clocked logic.

Parameters:
- N, 5, number of independent button channels (>=1).
- DEBOUNCE_CYCLES, 2000, consecutive stable synchronised cycles required to accept a level change (>=1).
- HOLD_CYCLES, 50000000, cycles the debounced level must stay high before long_press fires (>=1).
- REPEAT_EN, 0, 1 enables auto-repeat pulses after long_press; 0 disables them.
- REPEAT_CYCLES, 10000000, spacing of repeat pulses after long_press (>=1; ignored when REPEAT_EN=0).

Ports:
- clk  input  1  system clock; all state on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- bt  input  N  raw, asynchronous button inputs, active-high.
- level  output  N  debounced button state.
- press  output  N  one-cycle pulse on debounced 0->1.
- release  output  N  one-cycle pulse on debounced 1->0.
- long_press  output  N  one-cycle pulse when held HOLD_CYCLES.
- repeat  output  N  one-cycle auto-repeat pulse (REPEAT_EN=1 only).
- any_press  output  1  OR of press[N-1:0], same cycle.

Behaviour:
- Reset:
  - All state clears on rst assertion without waiting for clk: sync FFs, counters, level, press, release, long_press, repeat, any_press.
  - The first clk edge after deassertion starts sampling bt.
  - Reset mid-press drops level and suppresses any pending release pulse.
- Synchroniser: s[i] = bt[i] delayed by 2 clk edges.
- Debounce, per channel, counter dcnt of width $clog2(DEBOUNCE_CYCLES+1):
  - s==level: dcnt<=0.
  - s!=level and dcnt==DEBOUNCE_CYCLES-1: level<=s, dcnt<=0.
  - Otherwise dcnt<=dcnt+1.
  - A glitch shorter than DEBOUNCE_CYCLES cycles never changes level, because any return to the old value resets dcnt.
- Latency: from the first clk edge where bt is sampled high (and stays high) to level=1 is 2+DEBOUNCE_CYCLES edges. Release latency is identical.
- Pulses:
  - press and release are asserted for exactly one cycle, in the same cycle level changes.
  - press and release are mutually exclusive per channel.
- Hold FSM, per channel, with states IDLE, HOLDING, LONG:
  - IDLE: level=0. On press go to HOLDING with hcnt<=0.
  - HOLDING: hcnt++ each cycle. When hcnt==HOLD_CYCLES-1 and level is still 1, pulse long_press, go to LONG, rcnt<=0.
  - LONG, REPEAT_EN=1: rcnt++; when rcnt==REPEAT_CYCLES-1, pulse repeat and set rcnt<=0 (periodic).
  - LONG, REPEAT_EN=0: rcnt idles at 0.
  - Any state: release (level 1->0) returns to IDLE and clears hcnt and rcnt. No long_press or repeat in the release cycle or later.
  - long_press fires at most once per press. It is first asserted HOLD_CYCLES cycles after the press cycle.
- Counter widths come from $clog2 of the parameter; counters never wrap, since they are cleared at their terminal values.
- Channels are fully independent. Simultaneous presses on several channels pulse all corresponding press bits in the same cycle; any_press is a single 1.

Test Plan (N=4, DEBOUNCE_CYCLES=4, HOLD_CYCLES=10, REPEAT_EN=1, REPEAT_CYCLES=5):
- Reset:
  - Stimulus: rst=1 with bt=4'b1111 held, then rst=0.
  - Required: all outputs 0 during reset.
  - Required: level=4'b1111, press=4'b1111 and any_press=1 for one cycle, exactly 6 edges after deassertion.
- Glitch rejection:
  - Stimulus: bt[0] high for 3 cycles then low.
  - Required: level[0], press[0] and release[0] stay 0 throughout.
- Clean press and release:
  - Stimulus: bt[1] high for 20 cycles.
  - Required: press[1] 6 edges after the rise; release[1] 6 edges after the fall; one pulse each.
  - Required: long_press[1] 10 cycles after the press pulse.
- Auto-repeat:
  - Stimulus: bt[2] held for 40 cycles.
  - Required: long_press[2] at press+10.
  - Required: repeat[2] at press+15, +20, +25 and so on while level[2]=1; none after release.
- Independence:
  - Stimulus: bt[3] pressed while bt[2] is in the LONG state.
  - Required: channel 2's repeat spacing is unaffected; press[3] timing matches the single-channel case.
- Reset mid-hold:
  - Stimulus: rst pulsed at press+7 on channel 1.
  - Required: no long_press[1] and no release[1].
  - Required: press[1] re-fires 6 edges after deassertion if bt[1] is still high.
